// File: rtl/rx_stm_descrambler.sv
// rx_stm_descrambler: STM-1 receive framer and frame-synchronous descrambler.
// Hunts for the A1A1A1A2A2A2 pattern in the serial bit stream and tracks frame
// position through HUNT/PRESYNC/SYNC. It removes the 1+x^6+x^7 scrambling
// sequence, which restarts at the first bit after the row-1 SOH of every
// frame, and reports out-of-frame and loss-of-frame status.
// All outputs are registered, one bit per clk155 cycle, with 1-cycle latency.
module rx_stm_descrambler #(
  parameter int          FRAME_BITS = 19440,
  parameter int          UNSCR_BITS = 72,
  parameter logic [47:0] ALIGN_PAT  = 48'hF6F6F6282828,
  parameter int          OOF_ERRS   = 4,
  parameter int          LOF_FRAMES = 24
) (
  input  logic clk155,
  input  logic rst,
  input  logic rx_sdi,
  output logic rx_sdo,
  output logic sof,
  output logic dse,
  output logic oof,
  output logic lof
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int ERR_W = $clog2(OOF_ERRS + 1);
  localparam int LOF_W = $clog2(LOF_FRAMES + 1);

  // The frame bit on which the last A2 bit arrives, and the bit after it.
  localparam logic [CNT_W-1:0] CNT_CHECK   = CNT_W'(47);
  localparam logic [CNT_W-1:0] CNT_REALIGN = CNT_W'(48);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_UNSCR   = CNT_W'(UNSCR_BITS);
  localparam logic [ERR_W-1:0] ERR_LAST    = ERR_W'(OOF_ERRS - 1);
  localparam logic [LOF_W-1:0] LOF_LAST    = LOF_W'(LOF_FRAMES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [46:0]      sr_q,      sr_d;
  logic [6:0]       x_q,       x_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [LOF_W-1:0] lof_cnt_q, lof_cnt_d;
  logic             rx_sdo_q,  rx_sdo_d;
  logic             sof_q,     sof_d;
  logic             dse_q,     dse_d;
  logic             oof_q,     oof_d;
  logic             lof_q,     lof_d;

  logic match;
  logic at_check;
  logic at_wrap;
  logic desc_act;

  // The pattern compare includes the bit arriving now, so a match marks the
  // current bit as the last A2 bit.
  assign match    = ({sr_q, rx_sdi} == ALIGN_PAT);
  assign at_check = (cnt_q == CNT_CHECK);
  assign at_wrap  = (cnt_q == CNT_LAST);
  assign desc_act = (state_q != HUNT) && (cnt_q >= CNT_UNSCR);

  // Frame alignment FSM: bit counter, pattern history and framing-error count.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    oof_d     = oof_q;
    cnt_d     = at_wrap ? '0 : cnt_q + CNT_W'(1);
    sr_d      = {sr_q[45:0], rx_sdi};

    case (state_q)
      HUNT: begin
        if (match) begin
          state_d = PRESYNC;
          cnt_d   = CNT_REALIGN;
        end
      end
      PRESYNC: begin
        if (at_check) begin
          if (match) begin
            state_d   = SYNC;
            oof_d     = 1'b0;
            err_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
      end
      SYNC: begin
        // SYNC never realigns; only repeated misses at the expected position
        // drop it back to HUNT.
        if (at_check) begin
          if (match) begin
            err_cnt_d = '0;
          end else if (err_cnt_q == ERR_LAST) begin
            state_d   = HUNT;
            oof_d     = 1'b1;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Descrambler and frame markers for the bit being output next cycle.
  always_comb begin
    rx_sdo_d = rx_sdi;
    x_d      = 7'h7F;
    if (desc_act) begin
      rx_sdo_d = rx_sdi ^ x_q[6];
      x_d      = {x_q[5:0], x_q[6] ^ x_q[5]};
    end
    dse_d = desc_act;
    sof_d = (cnt_q == '0) && (state_q != HUNT);
  end

  // LOF integration: count consecutive frame periods whose OOF state argues
  // for toggling lof; any frame period that agrees with lof restarts the count.
  always_comb begin
    lof_d     = lof_q;
    lof_cnt_d = lof_cnt_q;
    if (at_wrap) begin
      if (oof_q != lof_q) begin
        if (lof_cnt_q == LOF_LAST) begin
          lof_d     = ~lof_q;
          lof_cnt_d = '0;
        end else begin
          lof_cnt_d = lof_cnt_q + LOF_W'(1);
        end
      end else begin
        lof_cnt_d = '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk155) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      // NOTE: the pattern history is reset too; otherwise stale bits could
      // complete a false match in the first 47 cycles after reset.
      sr_q      <= '0;
      x_q       <= 7'h7F;
      err_cnt_q <= '0;
      lof_cnt_q <= '0;
      rx_sdo_q  <= 1'b0;
      sof_q     <= 1'b0;
      dse_q     <= 1'b0;
      oof_q     <= 1'b1;
      lof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      x_q       <= x_d;
      err_cnt_q <= err_cnt_d;
      lof_cnt_q <= lof_cnt_d;
      rx_sdo_q  <= rx_sdo_d;
      sof_q     <= sof_d;
      dse_q     <= dse_d;
      oof_q     <= oof_d;
      lof_q     <= lof_d;
    end
  end

  assign rx_sdo = rx_sdo_q;
  assign sof    = sof_q;
  assign dse    = dse_q;
  assign oof    = oof_q;
  assign lof    = lof_q;

endmodule

// File: doc/rx_stm_descrambler.md
Name: rx_stm_descrambler

Overview:
- Receive-side counterpart of the TX frame-synchronous scrambler on the STM-1 serial path, one bit per clk155 cycle.
- Hunts for the A1/A2 framing pattern and tracks frame position through an HUNT/PRESYNC/SYNC state machine.
- Descrambles with the 1+x^6+x^7 sequence, restarted every frame, and reports OOF/LOF.
- Sits between the serial CDR input and the downstream RX serial-to-parallel/B1 check logic.

Parameters:
- FRAME_BITS, 19440: bits per STM-1 frame.
- UNSCR_BITS, 72: unscrambled bits at start of frame (row-1 SOH, 9 bytes).
- ALIGN_PAT, 48'hF6F6F6282828: A1A1A1A2A2A2, MSB = first received bit.
- OOF_ERRS, 4: consecutive framing-pattern errors in SYNC that force HUNT.
- LOF_FRAMES, 24: frame periods (3 ms) of persistent OOF to set LOF; same count of in-frame periods to clear it.

Ports:
- clk155  in  1  155.52 MHz bit clock.
- rst  in  1  Reset, synchronous, active-high.
- rx_sdi  in  1  Received scrambled serial bit.
- rx_sdo  out  1  Descrambled serial bit; 1-cycle latency.
- sof  out  1  Pulse aligned with rx_sdo carrying frame bit 0 (first A1 MSB).
- dse  out  1  High when rx_sdo is a descrambled (payload-region) bit.
- oof  out  1  Out-of-frame indication.
- lof  out  1  Loss-of-frame indication.

Behaviour:
- Reset values: state=HUNT, cnt=0, x=7'h7F, err_cnt=0, lof_cnt=0, shift reg=0, rx_sdo=0, sof=0, dse=0, oof=1, lof=0.
- Pattern detection:
  - 47-bit history sr holds {sr[45:0], rx_sdi}.
  - match = ({sr[46:0], rx_sdi} == ALIGN_PAT), evaluated combinationally on the current bit.
- Bit counter cnt, range 0..FRAME_BITS-1:
  - Free-running, wraps FRAME_BITS-1 -> 0 in every state.
  - A current bit at cnt=47 is the last A2 bit.
- State machine:
  - HUNT: match at any cnt -> PRESYNC, cnt<=48 (realign). Otherwise stay.
  - PRESYNC: pattern checked only when cnt==47. match -> SYNC, oof<=0, err_cnt<=0. mismatch -> HUNT. Matches at other cnt are ignored.
  - SYNC: checked only when cnt==47. match -> err_cnt<=0. mismatch -> err_cnt+1. On reaching OOF_ERRS -> HUNT, oof<=1, err_cnt<=0. No realignment in SYNC.
  - Entry into HUNT takes effect the next cycle. The pattern search resumes from that cycle. cnt continues uninterrupted.
- Descrambler:
  - desc_act = (state!=HUNT) && (cnt >= UNSCR_BITS).
  - If desc_act: rx_sdo<=rx_sdi^x[6] and x<={x[5:0], x[6]^x[5]}.
  - Else: rx_sdo<=rx_sdi and x<=7'h7F.
  - dse<=desc_act.
  - Sequence therefore restarts at 1111111 at frame bit 72 every frame.
- sof <= (cnt==0) && (state!=HUNT). It is registered, so it coincides with rx_sdo of bit 0.
- oof changes only on the transitions above; it stays 1 through PRESYNC.
- LOF:
  - At each cnt wrap, lof_cnt counts consecutive frame periods.
  - While lof=0: increment when oof=1, clear when oof=0. Reaching LOF_FRAMES sets lof=1 and clears lof_cnt.
  - While lof=1: increment when oof=0, clear when oof=1. Reaching LOF_FRAMES clears lof and lof_cnt.
- Simultaneous events: an OOF_ERRS-th error and a cnt wrap cannot coincide, since the check is at cnt==47. A HUNT match at cnt==47 is treated as realignment only.
- rst mid-frame returns everything to reset values on the next edge.

Test Plan:
- Clean frames: 3 frames of A1A1A1A2A2A2, then TX-scrambled all-zero payload -> oof falls at the 2nd frame's cnt==47. From the 2nd frame onward:
  - rx_sdo payload = 0.
  - Raw bits 72..85 equal 11111110000001.
  - sof pulses every 19440 cycles.
  - dse rises at bit 72 and falls at bit 0.
- False pattern: a single F6F6F6282828 in random data, not repeated -> PRESYNC, then HUNT at the next cnt==47. oof stays 1.
- Error tolerance: in SYNC, corrupt A2 in 3 consecutive frames, then a clean frame -> oof stays 0 and err_cnt returns to 0. Corrupt 4 consecutive frames -> oof=1 the cycle after the 4th check.
- LOF: remove framing for 24 frame periods -> lof=1 at the 24th wrap. Restore framing -> lof clears after 24 in-frame periods.
- Realignment: shift the stream by 5 bits while in SYNC -> OOF after 4 frames, then reacquire with sof moved 5 cycles. Payload is descrambled correctly afterwards.
- Reset mid-SYNC: assert rst for 1 cycle at cnt=1000 -> the next cycle shows oof=1, lof=0, dse=0, sof=0, state HUNT.
